// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the keypad scanner slice.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package keypad_scanner_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } kp_state_e;

    typedef enum logic [1:0] {
        SCAN_NONE,
        SCAN_ONE,
        SCAN_MULTI
    } scan_kind_e;

    typedef struct packed {
        scan_kind_e kind;
        logic [3:0] code;
    } scan_res_t;

    // cnt saturates at 2, so any value >= 2 means "ambiguous".
    function automatic scan_res_t classify(input logic [1:0] cnt, input logic [3:0] code);
        scan_res_t r;
        r.code = code;
        case (cnt)
            2'd0:    r.kind = SCAN_NONE;
            2'd1:    r.kind = SCAN_ONE;
            default: r.kind = SCAN_MULTI;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key event bus from the scanner to the control logic.
// Latency: n/a (wires only); master drives, slave observes.
// Backpressure: none, key_valid is a one-cycle strobe that is never stalled.
// Optional entry_num exists only when KEYPAD_ENTRY_EN is defined.
interface keypad_scanner_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
`ifdef KEYPAD_ENTRY_EN
    logic [31:0] entry_num;
`endif

    modport master (
        output key_valid,
        output key_code,
        output key_held
`ifdef KEYPAD_ENTRY_EN
        , output entry_num
`endif
    );

    modport slave (
        input key_valid,
        input key_code,
        input key_held
`ifdef KEYPAD_ENTRY_EN
        , input entry_num
`endif
    );
endinterface

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer, W bits wide, for asynchronous pin inputs.
// Latency: 2 clk cycles.
// Backpressure: none.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronized out).
module keypad_scanner_sync2 #(
    parameter int           W         = 4,
    parameter logic [W-1:0] RST_VAL   = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: row mux, debounce, single-key decode, press strobe.
// Latency: key_valid one cycle after the scan that completes DEBOUNCE_SCANS clean scans.
// Backpressure: none, one-cycle key_valid strobe per accepted press.
// Ports: clk, rst (sync, active-high), row_n (row drive), col_n (async column sense),
//        kp (key_valid/key_code/key_held, plus entry_num when KEYPAD_ENTRY_EN is defined).
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int ROW_DIV_W      = 10,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ROWS-1:0]     row_n,
    input  logic [COLS-1:0]     col_n,
    keypad_scanner_if.master    kp
);
    localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

    logic [ROW_DIV_W-1:0] div_cnt;
    logic [1:0]           row_idx;
    logic [COLS-1:0]      col_s;

    logic [1:0]           acc_cnt, acc_cnt_nxt;
    logic [3:0]           acc_first, acc_first_nxt;
    scan_res_t            scan_res;

    kp_state_e            state;
    logic [3:0]           db_cnt;
    logic [3:0]           cand;
    logic                 key_valid_q;
    logic [3:0]           key_code_q;
    logic                 key_held_q;

    // Sampling on the last cycle of a row gives the pins and synchronizer a
    // full row period to settle after the drive changes.
    wire row_end  = &div_cnt;
    wire scan_end = row_end && (row_idx == 2'd3);

    keypad_scanner_sync2 #(.W(COLS), .RST_VAL({COLS{1'b1}})) u_col_sync (
        .clk (clk),
        .rst (rst),
        .d   (col_n),
        .q   (col_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            row_idx <= 2'd0;
            row_n   <= 4'b1110;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            if (row_end) begin
                row_idx <= row_idx + 2'd1;
                row_n   <= ~(4'b0001 << (row_idx + 2'd1));
            end
        end
    end

    // Fold this row's columns into the running scan; first hit in scan order wins.
    always_comb begin
        acc_cnt_nxt   = acc_cnt;
        acc_first_nxt = acc_first;
        for (int c = 0; c < COLS; c++) begin
            if (!col_s[c]) begin
                if (acc_cnt_nxt == 2'd0)
                    acc_first_nxt = {row_idx, 2'(c)};
                if (acc_cnt_nxt != 2'd2)
                    acc_cnt_nxt = acc_cnt_nxt + 2'd1;
            end
        end
        scan_res = classify(acc_cnt_nxt, acc_first_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt   <= 2'd0;
            acc_first <= 4'h0;
        end else if (row_end) begin
            if (scan_end) begin
                acc_cnt   <= 2'd0;
                acc_first <= 4'h0;
            end else begin
                acc_cnt   <= acc_cnt_nxt;
                acc_first <= acc_first_nxt;
            end
        end
    end

`ifdef KEYPAD_ENTRY_EN
    logic [31:0] entry_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            db_cnt      <= 4'd0;
            cand        <= 4'h0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_ENTRY_EN
            entry_q     <= 32'h0;
`endif
        end else begin
            key_valid_q <= 1'b0;
            if (scan_end) begin
                case (state)
                    IDLE: begin
                        if (scan_res.kind == SCAN_ONE) begin
                            cand <= scan_res.code;
                            if (DB_N == 4'd1) begin
                                key_code_q  <= scan_res.code;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                state       <= HELD;
`ifdef KEYPAD_ENTRY_EN
                                entry_q     <= {entry_q[27:0], scan_res.code};
`endif
                            end else begin
                                db_cnt <= 4'd1;
                                state  <= PRESS_DB;
                            end
                        end
                    end
                    PRESS_DB: begin
                        if (scan_res.kind == SCAN_ONE && scan_res.code == cand) begin
                            if (db_cnt + 4'd1 == DB_N) begin
                                key_code_q  <= cand;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                state       <= HELD;
`ifdef KEYPAD_ENTRY_EN
                                entry_q     <= {entry_q[27:0], cand};
`endif
                            end else begin
                                db_cnt <= db_cnt + 4'd1;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                    HELD: begin
                        // Any key activity (even a different or ambiguous one) keeps the hold.
                        if (scan_res.kind == SCAN_NONE) begin
                            if (DB_N == 4'd1) begin
                                key_held_q <= 1'b0;
                                state      <= IDLE;
                            end else begin
                                db_cnt <= 4'd1;
                                state  <= RELEASE_DB;
                            end
                        end
                    end
                    RELEASE_DB: begin
                        if (scan_res.kind == SCAN_NONE) begin
                            if (db_cnt + 4'd1 == DB_N) begin
                                key_held_q <= 1'b0;
                                state      <= IDLE;
                            end else begin
                                db_cnt <= db_cnt + 4'd1;
                            end
                        end else begin
                            state <= HELD;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign kp.key_valid = key_valid_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_held  = key_held_q;
`ifdef KEYPAD_ENTRY_EN
    assign kp.entry_num = entry_q;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner at ROW_DIV_W=2 (16-cycle scan), DEBOUNCE_SCANS=3.
// Scans complete on posedges where cyc (posedges since reset) is a multiple of 16;
// keys change 1ns after such an edge so each scan sees a clean pattern.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] keys = 16'h0;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int vld_cycles = 0;
    int last_vld_cyc = -1;
    int held_hi = 0;

    keypad_scanner_if kif();

    keypad_scanner #(.ROW_DIV_W(2), .DEBOUNCE_SCANS(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .row_n (row_n),
        .col_n (col_n),
        .kp    (kif)
    );

    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_n[r])
                    col_n[c] = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (kif.key_valid) begin
            vld_cycles   = vld_cycles + 1;
            last_vld_cyc = cyc;
        end
        if (kif.key_held)
            held_hi = held_hi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic to_boundary();
        int i;
        i = 0;
        tick(1);
        while ((cyc % 16) != 0 && i < 40) begin
            tick(1);
            i++;
        end
        if ((cyc % 16) != 0)
            chk("scan_align_timeout", 32'(cyc % 16), 32'd0);
    endtask

    task automatic press_release(input int k, input string tag);
        int v0;
        to_boundary();
        v0 = vld_cycles;
        keys[k] = 1'b1;
        tick(64);
        chk({tag, "_strobes"}, 32'(vld_cycles - v0), 32'd1);
        chk({tag, "_code"}, 32'(kif.key_code), 32'(k));
        keys = 16'h0;
        tick(80);
    endtask

    int t0, v0, h0, c0;

    initial begin
        // Reset state
        rst = 1'b1;
        tick(3);
        chk("rst_row_n", 32'(row_n), 32'hE);
        chk("rst_key_valid", 32'(kif.key_valid), 32'd0);
        chk("rst_key_code", 32'(kif.key_code), 32'd0);
        chk("rst_key_held", 32'(kif.key_held), 32'd0);
`ifdef KEYPAD_ENTRY_EN
        chk("rst_entry_num", kif.entry_num, 32'h0);
`endif
        rst = 1'b0;

        // Key 5 pressed for 5 scans: one strobe, 3 scans after press
        to_boundary();
        t0 = cyc; v0 = vld_cycles;
        keys[5] = 1'b1;
        tick(80);
        chk("k5_strobes", 32'(vld_cycles - v0), 32'd1);
        chk("k5_strobe_cyc", 32'(last_vld_cyc), 32'(t0 + 48));
        chk("k5_code", 32'(kif.key_code), 32'h5);
        chk("k5_held", 32'(kif.key_held), 32'd1);
        keys = 16'h0;
        tick(80);
        chk("k5_released", 32'(kif.key_held), 32'd0);

        // Key B for only 2 scans: rejected, key_code keeps last value
        to_boundary();
        v0 = vld_cycles; h0 = held_hi;
        keys[11] = 1'b1;
        tick(32);
        keys = 16'h0;
        tick(64);
        chk("short_strobes", 32'(vld_cycles - v0), 32'd0);
        chk("short_held_cycles", 32'(held_hi - h0), 32'd0);
        chk("short_code_kept", 32'(kif.key_code), 32'h5);

        // Keys 0 and 1 together: ambiguous, then key 0 alone is accepted
        to_boundary();
        v0 = vld_cycles;
        keys[0] = 1'b1; keys[1] = 1'b1;
        tick(96);
        chk("multi_strobes", 32'(vld_cycles - v0), 32'd0);
        chk("multi_held", 32'(kif.key_held), 32'd0);
        keys[1] = 1'b0;
        t0 = cyc;
        tick(64);
        chk("k0_strobes", 32'(vld_cycles - v0), 32'd1);
        chk("k0_strobe_cyc", 32'(last_vld_cyc), 32'(t0 + 48));
        chk("k0_code", 32'(kif.key_code), 32'h0);
        keys = 16'h0;
        tick(80);
        chk("k0_released", 32'(kif.key_held), 32'd0);

        // Key F long hold with a one-scan dropout, then exact release timing
        to_boundary();
        t0 = cyc; v0 = vld_cycles;
        keys[15] = 1'b1;
        tick(160);
        h0 = held_hi; c0 = cyc;
        keys[15] = 1'b0;
        tick(16);
        keys[15] = 1'b1;
        tick(160);
        chk("kf_held_through_glitch", 32'(held_hi - h0), 32'(cyc - c0));
        chk("kf_strobes", 32'(vld_cycles - v0), 32'd1);
        chk("kf_strobe_cyc", 32'(last_vld_cyc), 32'(t0 + 48));
        chk("kf_code", 32'(kif.key_code), 32'hF);
        keys = 16'h0;
        tick(47);
        chk("kf_held_before_drop", 32'(kif.key_held), 32'd1);
        tick(1);
        chk("kf_held_after_drop", 32'(kif.key_held), 32'd0);
        chk("kf_strobes_final", 32'(vld_cycles - v0), 32'd1);

        // Reset in the middle of press debounce: fresh debounce afterwards
        to_boundary();
        v0 = vld_cycles;
        keys[5] = 1'b1;
        tick(40);
        chk("rstmid_no_strobe_yet", 32'(vld_cycles - v0), 32'd0);
        rst = 1'b1;
        tick(1);
        chk("rstmid_row_n", 32'(row_n), 32'hE);
        chk("rstmid_code", 32'(kif.key_code), 32'h0);
        chk("rstmid_held", 32'(kif.key_held), 32'd0);
        rst = 1'b0;
        tick(40);
        chk("rstmid_no_early_strobe", 32'(vld_cycles - v0), 32'd0);
        tick(24);
        chk("rstmid_strobes", 32'(vld_cycles - v0), 32'd1);
        chk("rstmid_strobe_cyc", 32'(last_vld_cyc), 32'd48);
        chk("rstmid_code_after", 32'(kif.key_code), 32'h5);
        keys = 16'h0;
        tick(80);

        // Digit sequence 1, 2, 3 from a clean reset
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
`ifdef KEYPAD_ENTRY_EN
        chk("entry_after_rst", kif.entry_num, 32'h0);
`endif
        press_release(1, "seq1");
        press_release(2, "seq2");
        press_release(3, "seq3");
`ifdef KEYPAD_ENTRY_EN
        chk("entry_123", kif.entry_num, 32'h0000_0123);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4×4 active-low key matrix by time-multiplexing row drives, the input-side counterpart of the multiplexed seven-segment display driver. It debounces the column reads, resolves a single pressed key into a 4-bit hex code, and emits a one-cycle strobe per accepted press. It sits between the board keypad pins and the stopwatch control logic. Optionally, it accumulates entered digits into a 32-bit value in the same nibble format the display driver consumes.

## Interface
- ROW_DIV_W, 10: row period is 2^ROW_DIV_W clk cycles.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release (range 1..15).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- row_n  output  4  row drive, active-low, exactly one bit low at any time.
- col_n  input  4  column sense, active-low, externally pulled up, asynchronous.
- key_valid  output  1  one-cycle strobe per accepted press.
- key_code  output  4  code of last accepted key, {row_idx[1:0], col_idx[1:0]}.
- key_held  output  1  high while an accepted key remains pressed.
- entry_num  output  32  digit accumulator; present only with KEYPAD_ENTRY_EN.

## Operation
- Prescaler `div_cnt` (ROW_DIV_W bits) free-runs; row index `row_idx` (2 bits) increments when `div_cnt` is all ones, wrapping 3→0.
- row_n = ~(4'b0001 << row_idx), registered.
- col_n passes through a 2-flop synchronizer. The sample is taken on the last cycle of each row period (`div_cnt` all ones), giving a full period for settling.
- Per-scan accumulator records the pressed-key count and the first key {row_idx, col_idx} found in scan order (row 0 first, col 0 first). It is evaluated at the end of row 3, then cleared.
- Scan result: NONE (0 keys), ONE(code) (exactly 1), MULTI (≥2; treated as ambiguous).
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB. A 4-bit `db_cnt` counts scans.
  - IDLE: on ONE(c), latch cand=c, db_cnt=1, go PRESS_DB. NONE or MULTI: stay.
  - PRESS_DB: on ONE(cand), db_cnt++. On reaching DEBOUNCE_SCANS: key_code<=cand, pulse key_valid, go HELD. Any other result: go IDLE.
  - HELD: key_held=1. On NONE, db_cnt=1, go RELEASE_DB. ONE (any code) or MULTI: stay, no new strobe.
  - RELEASE_DB: on NONE, db_cnt++. On reaching DEBOUNCE_SCANS: go IDLE. On ONE or MULTI: go HELD.
- With DEBOUNCE_SCANS=1, the transition fires on the first qualifying scan.
- key_code holds its value until the next accepted press.

## Timing
- Reset values: row_n=4'b1110, key_valid=0, key_code=4'h0, key_held=0, entry_num=32'h0. Reset also sets div_cnt=0, row_idx=0, accumulator clear, FSM state=IDLE.
- Full scan takes 4·2^ROW_DIV_W cycles.
- key_valid rises the cycle after the scan evaluation that completes debounce. key_code updates in the same cycle.
- key_held rises together with key_valid and falls in the cycle after the release-debounce completes.
- Minimum press-to-strobe time is DEBOUNCE_SCANS full scans, plus up to one scan of alignment, plus 2 synchronizer cycles.
- Reset asserted mid-debounce or mid-hold aborts immediately with no strobe. After release, the key must be re-debounced from IDLE.

## Configuration
- KEYPAD_ENTRY_EN defined: entry_num port exists. On each key_valid, entry_num <= {entry_num[27:0], key_code}, shifted in the same cycle as the strobe. Its format matches the display driver's disp_num.
- KEYPAD_ENTRY_EN undefined: the port and register are absent; all other behaviour is identical.

## Structure
- Shared package holds: the FSM state enum (IDLE, PRESS_DB, HELD, RELEASE_DB), the scan-result encoding, and the constants ROWS=4 and COLS=4.
- Natural sub-module: `sync2`, a 2-flop synchronizer instantiated 4 wide for col_n.

## Test plan
Bench runs at ROW_DIV_W=2, DEBOUNCE_SCANS=3.
- Press row 1/col 1 for 5 scans → exactly one key_valid, key_code=4'h5, key_held=1.
- Press row 2/col 3 for only 2 scans, then release → no key_valid, key_held stays 0.
- Hold key 0 and key 1 simultaneously for 6 scans → no key_valid. Then release key 1 → key 0 is accepted, key_code=4'h0.
- Hold key F for 20 scans, glitch NONE for 1 scan mid-hold, then release → single strobe. key_held drops exactly 3 scans (+1 cycle) after release.
- Assert rst for 1 cycle during PRESS_DB → no strobe, row_n=4'b1110 next cycle. Press continues → strobe only after a fresh 3-scan debounce.
- With KEYPAD_ENTRY_EN: press 1, 2, 3 in sequence → entry_num=32'h0000_0123.
